xmt: RTL and testbench
======================

XMT -- requirements
Module: xmt

Interface
REQ-001 SHALL have parameter: BIT_DURATION_CLOCKS, 500, clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port: load  input  1  byte-offer strobe, sampled on rising clk edges.
REQ-005 SHALL have port: parallel_in  input  8  byte to transmit, sampled with load.
REQ-006 SHALL have port: ready  output  1  holding register empty; load is accepted only when 1.
REQ-007 SHALL have port: idle  output  1  holding register empty and no frame in progress.
REQ-008 SHALL have port: serial_out  output  1  registered serial line, idle-high, 8N1 framing.

Function
REQ-009 SHALL transmit frames of 8N1 format: start bit 0, data bits 0..7 LSB first, stop bit 1.
REQ-010 SHALL hold each frame bit on serial_out for exactly BIT_DURATION_CLOCKS cycles; full frame = 10*BIT_DURATION_CLOCKS cycles.
REQ-011 SHALL use a 16-bit bit-duration counter reloaded at every bit boundary; no wrap-around within a bit.
REQ-012 SHALL contain a one-byte holding register plus a frame shifter, giving one byte of buffering ahead of the active frame.
REQ-013 SHALL capture parallel_in into the holding register at an edge where load=1 and ready=1; ready SHALL be 0 from the following cycle.
REQ-014 SHALL ignore load when ready=0; holding register and active frame unaffected.
REQ-015 SHALL implement frame-engine states IDLE, START, DATA, STOP; DATA tracks bit index 0..7.
REQ-016 IDLE: serial_out=1; if holding register full, at next edge transfer it to shifter, clear holding register (ready=1), enter START.
REQ-017 Latency: load accepted at edge E0 with engine IDLE -> serial_out falls to 0 after edge E0+1.
REQ-018 START -> DATA after BIT_DURATION_CLOCKS cycles; DATA shifts out one bit per period; after bit 7 -> STOP.
REQ-019 STOP end: if holding register full, transfer and enter START at that same edge (no idle gap); else enter IDLE.
REQ-020 Load accepted at the same edge as a STOP-end transfer SHALL be impossible (ready=0 that cycle); ready SHALL rise the cycle after transfer.
REQ-021 Holding register SHALL be freed only on transfer to shifter; a byte accepted during an active frame SHALL be sent next, unaltered.
REQ-022 idle SHALL be 1 exactly when engine is IDLE and holding register empty; 0 from the cycle after an accepted load.
REQ-023 serial_out SHALL be driven directly from a flip-flop (glitch-free).

Reset
REQ-024 reset=0 SHALL immediately, asynchronously force serial_out=1, ready=1, idle=1, engine IDLE, holding register empty, counter 0.
REQ-025 reset during a frame SHALL abandon the frame and any held byte; nothing resumes after release.
REQ-026 After reset release, first accepted load SHALL follow REQ-017 timing exactly.

Verification (BIT_DURATION_CLOCKS=4 unless stated)
REQ-027 Single byte: load 0x55 at edge E0 from idle -> serial_out low from E0+1 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), stop high 4 cycles, idle=1 at E0+41.
REQ-028 Back-to-back: load 0xA5 then 0x3C as soon as ready=1 -> 80 contiguous cycles of two frames, no high gap between stop of 0xA5 and start of 0x3C; ready=0 while holding full.
REQ-029 Ignored load: with holding full, pulse load with 0xFF -> transmitted stream unchanged, ready stays 0 until transfer.
REQ-030 Reset mid-frame: assert reset during data bit 3 of 0x0F -> serial_out=1 immediately (before next clk edge), ready=1, idle=1; line stays high after release.
REQ-031 Boundary: BIT_DURATION_CLOCKS=2, load 0x00 -> start+8 data bits low for 18 cycles, stop high 2 cycles; BIT_DURATION_CLOCKS=65535 frame length 655350 cycles.

Source files
------------

// File: rtl/xmt.sv
// 8N1 serial transmitter: a one-byte holding register feeding a frame shifter.
// The line idles high and each frame bit is held for BIT_DURATION_CLOCKS cycles.
module xmt #(
  parameter int unsigned BIT_DURATION_CLOCKS = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] parallel_in,
  output logic       ready,
  output logic       idle,
  output logic       serial_out,
  output logic [1:0] engine_state
);

  // load/ready handshake: a byte is taken at a rising edge where load=1 and
  // ready=1. ready drops the following cycle and rises again the cycle after
  // the held byte moves into the shifter. load while ready=0 is ignored.

  // engine_state encoding: 0=IDLE 1=START 2=DATA 3=STOP
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0] LAST_CNT = 16'(BIT_DURATION_CLOCKS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [7:0]  hold;
  logic        hold_full;
  logic [7:0]  shifter;
  logic [2:0]  bit_idx;

  logic        bit_end;
  logic        transfer;
  logic        accept;
  logic        shift_en;
  logic        serial_nxt;

  assign bit_end  = (state != S_IDLE) && (cnt == LAST_CNT);
  assign accept   = load && !hold_full;
  assign shift_en = (state == S_DATA) && bit_end;
  assign transfer = hold_full &&
                    ((state == S_IDLE) || ((state == S_STOP) && bit_end));

  assign ready        = !hold_full;
  assign idle         = (state == S_IDLE) && !hold_full;
  assign engine_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (hold_full) state_nxt = S_START;
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA:  if (bit_end && (bit_idx == 3'd7)) state_nxt = S_STOP;
      S_STOP:  if (bit_end) state_nxt = hold_full ? S_START : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next line level; a pending byte at stop end starts its frame with no gap.
  always_comb begin
    serial_nxt = serial_out;
    case (state)
      S_IDLE:  serial_nxt = !hold_full;
      S_START: if (bit_end) serial_nxt = shifter[0];
      S_DATA:  if (bit_end) serial_nxt = (bit_idx == 3'd7) ? 1'b1 : shifter[1];
      S_STOP:  if (bit_end) serial_nxt = !hold_full;
      default: serial_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      serial_out <= 1'b1;
      hold       <= 8'h00;
      hold_full  <= 1'b0;
      shifter    <= 8'h00;
      cnt        <= 16'h0000;
      bit_idx    <= 3'd0;
    end else begin
      serial_out <= serial_nxt;

      if (accept) begin
        hold      <= parallel_in;
        hold_full <= 1'b1;
      end else if (transfer) begin
        hold_full <= 1'b0;
      end

      if (transfer)      shifter <= hold;
      else if (shift_en) shifter <= {1'b0, shifter[7:1]};

      if (transfer || bit_end)  cnt <= 16'h0000;
      else if (state != S_IDLE) cnt <= cnt + 16'd1;

      if ((state == S_START) && bit_end) bit_idx <= 3'd0;
      else if (shift_en)                 bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_xmt.sv
// Bench for xmt: per-cycle scoreboard of {serial_out, ready, idle} for a table
// of frames (bit period 4), plus reset and bit-period-2 corner sequences.
module tb_xmt;

  localparam int B  = 4;
  localparam int B2 = 2;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] parallel_in;
  logic       ready, idle, serial_out;
  logic [1:0] engine_state;

  logic       load2;
  logic [7:0] parallel_in2;
  logic       ready2, idle2, serial_out2;
  logic [1:0] engine_state2;

  int checks = 0;
  int passes = 0;

  logic [2:0] exp_q[$];

  typedef struct {
    logic [7:0] d0;
    logic       two;
    logic [7:0] d1;
    logic       junk;
  } vec_t;

  vec_t vecs[5];

  xmt #(.BIT_DURATION_CLOCKS(B)) dut (
    .clk(clk), .reset(reset), .load(load), .parallel_in(parallel_in),
    .ready(ready), .idle(idle), .serial_out(serial_out),
    .engine_state(engine_state)
  );

  xmt #(.BIT_DURATION_CLOCKS(B2)) dut2 (
    .clk(clk), .reset(reset), .load(load2), .parallel_in(parallel_in2),
    .ready(ready2), .idle(idle2), .serial_out(serial_out2),
    .engine_state(engine_state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got {serial,ready,idle}=%b expected %b", name, act, exp);
  endtask

  // Frame bit b (0..9) of an 8N1 frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  // Offer d0 from idle; optionally queue d1 as soon as ready=1 and pulse a
  // rejected 0xFF load while d1 is held. Checks every cycle after acceptance.
  task automatic run_vec(input int id, input vec_t v);
    logic [2:0] exp;
    exp_q.delete();
    exp_q.push_back(3'b100);
    for (int k = 0; k < 10*B; k++)
      exp_q.push_back({frame_bit(v.d0, k/B), (v.two && k >= 1) ? 1'b0 : 1'b1, 1'b0});
    if (v.two)
      for (int k = 0; k < 10*B; k++)
        exp_q.push_back({frame_bit(v.d1, k/B), 1'b1, 1'b0});
    exp_q.push_back(3'b111);
    exp_q.push_back(3'b111);

    @(negedge clk);
    load = 1'b1;
    parallel_in = v.d0;
    @(negedge clk);
    load = 1'b0;
    for (int j = 0; exp_q.size() > 0; j++) begin
      exp = exp_q.pop_front();
      check($sformatf("vec%0d cyc%0d", id, j), {serial_out, ready, idle}, exp);
      if (v.two && j == 1) begin
        load = 1'b1;
        parallel_in = v.d1;
      end else if (v.junk && j == 20) begin
        load = 1'b1;
        parallel_in = 8'hFF;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  // Start a frame of d, optionally fill the holding register, then assert
  // reset mid-way through frame bit fb and check the outputs before any edge.
  task automatic reset_mid(input string name, input logic [7:0] d, input int fb,
                           input logic hold2);
    @(negedge clk);
    load = 1'b1;
    parallel_in = d;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    if (hold2) begin
      load = 1'b1;
      parallel_in = 8'hC3;
    end
    @(negedge clk);
    load = 1'b0;
    repeat (fb*B + B/2 - 1) @(negedge clk);
    check({name, " pre-reset"}, {serial_out, ready, idle},
          {frame_bit(d, fb), !hold2, 1'b0});
    #2 reset = 1'b0;
    #1 check({name, " async"}, {serial_out, ready, idle}, 3'b111);
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 12*B; j++) begin
      @(negedge clk);
      check($sformatf("%s after-release cyc%0d", name, j), {serial_out, ready, idle}, 3'b111);
    end
  endtask

  initial begin
    logic [2:0] exp;
    reset = 1'b0;
    load = 1'b0;
    parallel_in = 8'h00;
    load2 = 1'b0;
    parallel_in2 = 8'h00;

    vecs[0] = '{d0: 8'h55, two: 1'b0, d1: 8'h00, junk: 1'b0};
    vecs[1] = '{d0: 8'hA5, two: 1'b1, d1: 8'h3C, junk: 1'b0};
    vecs[2] = '{d0: 8'h12, two: 1'b1, d1: 8'h34, junk: 1'b1};
    vecs[3] = '{d0: 8'h00, two: 1'b0, d1: 8'h00, junk: 1'b0};
    vecs[4] = '{d0: 8'hFF, two: 1'b0, d1: 8'h00, junk: 1'b0};

    repeat (3) @(negedge clk);
    check("reset dut", {serial_out, ready, idle}, 3'b111);
    check("reset dut2", {serial_out2, ready2, idle2}, 3'b111);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle after release", {serial_out, ready, idle}, 3'b111);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    reset_mid("rst data bit3 0x0F", 8'h0F, 4, 1'b0);
    reset_mid("rst start bit held", 8'h0F, 0, 1'b1);
    reset_mid("rst data bit5 0x0F", 8'h0F, 6, 1'b1);

    run_vec(5, vecs[0]);

    // Shortest bit period: 0x00 gives 18 low cycles then 2 high.
    exp_q.delete();
    exp_q.push_back(3'b100);
    for (int k = 0; k < 10*B2; k++) exp_q.push_back({k >= 9*B2, 1'b1, 1'b0});
    exp_q.push_back(3'b111);
    exp_q.push_back(3'b111);
    @(negedge clk);
    load2 = 1'b1;
    parallel_in2 = 8'h00;
    @(negedge clk);
    load2 = 1'b0;
    for (int j = 0; exp_q.size() > 0; j++) begin
      exp = exp_q.pop_front();
      check($sformatf("bit2 cyc%0d", j), {serial_out2, ready2, idle2}, exp);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
